// File: rtl/sm83_pkg.sv
// sm83_pkg: shared register map, bus types and timer state encoding for the
// SM83 peripheral blocks.
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  localparam addr_t TIMER_DIV_ADDR  = 16'hFF04;
  localparam addr_t TIMER_TIMA_ADDR = 16'hFF05;
  localparam addr_t TIMER_TMA_ADDR  = 16'hFF06;
  localparam addr_t TIMER_TAC_ADDR  = 16'hFF07;

  typedef enum logic [1:0] {
    RUN,
    OVF,
    RELOAD
  } timer_state_t;

  // Pick the divider bit that clocks TIMA for a given TAC clock-select field.
  function automatic logic tac_tap(input logic [1:0] clk_sel, input logic [15:0] cnt);
    logic t;
    case (clk_sel)
      2'b00:   t = cnt[9];
      2'b01:   t = cnt[3];
      2'b10:   t = cnt[5];
      default: t = cnt[7];
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sm83_timer.sv
// sm83_timer: DIV/TIMA/TMA/TAC timer block of the SM83 system.
// TIMA counts falling edges of the selected divider tap (gated by TAC[2]),
// so writes to DIV or TAC that pull the tap low also count.
// Build option SM83_TIMER_OVF_DELAY_EN: when defined, a TIMA wrap goes through
// a 3-clk OVF window (TIMA reads 0x00) and a 1-clk RELOAD before TMA is loaded;
// when undefined, TMA is loaded on the wrapping edge itself.
// irq_timer rises one clk after the clk on which TMA is loaded into TIMA.
module sm83_timer
  import sm83_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  addr_t addr,
  input  data_t w_data,
  input  logic  w_wen,
  output data_t r_data,
  output logic  sel,
  output logic  irq_timer
);

  logic [15:0] sys_cnt;
  data_t       tima;
  data_t       tma;
  logic [2:0]  tac;
  logic        tick;
  logic        tick_prev;
  logic        fall;
  logic        div_wr;
  logic        tima_wr;
  logic        tma_wr;
  logic        tac_wr;
  data_t       tima_nxt;
  logic        reload_evt;
  logic        reload_p0;

  assign sel     = (addr[15:2] == TIMER_DIV_ADDR[15:2]);
  assign div_wr  = w_wen && (addr == TIMER_DIV_ADDR);
  assign tima_wr = w_wen && (addr == TIMER_TIMA_ADDR);
  assign tma_wr  = w_wen && (addr == TIMER_TMA_ADDR);
  assign tac_wr  = w_wen && (addr == TIMER_TAC_ADDR);

  assign tick = tac[2] & tac_tap(tac[1:0], sys_cnt);
  assign fall = tick_prev & ~tick;

  // Read mux for the four timer registers; unused TAC bits read as ones.
  always_comb begin
    r_data = '0;
    if (sel) begin
      case (addr[1:0])
        2'd0:    r_data = sys_cnt[15:8];
        2'd1:    r_data = tima;
        2'd2:    r_data = tma;
        default: r_data = {5'b11111, tac};
      endcase
    end
  end

  // Free-running divider; any DIV write clears the whole 16-bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n)      sys_cnt <= '0;
    else if (div_wr) sys_cnt <= '0;
    else             sys_cnt <= sys_cnt + 16'd1;
  end

  // TMA/TAC storage and tick history for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tma       <= '0;
      tac       <= '0;
      tick_prev <= 1'b0;
    end else begin
      if (tma_wr) tma <= w_data;
      if (tac_wr) tac <= w_data[2:0];
      tick_prev <= tick;
    end
  end

`ifdef SM83_TIMER_OVF_DELAY_EN
  timer_state_t state;
  timer_state_t state_nxt;
  logic [1:0]   ovf_cnt;
  logic [1:0]   ovf_cnt_nxt;

  // Overflow sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      ovf_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ovf_cnt <= ovf_cnt_nxt;
    end
  end

  // Next TIMA value and overflow sequencing; ticks are ignored outside RUN.
  always_comb begin
    state_nxt   = state;
    ovf_cnt_nxt = ovf_cnt;
    tima_nxt    = tima;
    reload_evt  = 1'b0;
    case (state)
      RUN: begin
        if (tima_wr) begin
          tima_nxt = w_data;
        end else if (fall) begin
          if (tima == 8'hFF) begin
            tima_nxt    = '0;
            state_nxt   = OVF;
            ovf_cnt_nxt = '0;
          end else begin
            tima_nxt = tima + 8'd1;
          end
        end
      end
      OVF: begin
        if (tima_wr) begin
          tima_nxt  = w_data;
          state_nxt = RUN;
        end else begin
          ovf_cnt_nxt = ovf_cnt + 2'd1;
          if (ovf_cnt == 2'd2) state_nxt = RELOAD;
        end
      end
      RELOAD: begin
        tima_nxt   = tma_wr ? w_data : tma;
        reload_evt = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end
`else
  // Next TIMA value; a wrap reloads TMA on the same edge.
  always_comb begin
    tima_nxt   = tima;
    reload_evt = 1'b0;
    if (tima_wr) begin
      tima_nxt = w_data;
    end else if (fall) begin
      if (tima == 8'hFF) begin
        tima_nxt   = tma;
        reload_evt = 1'b1;
      end else begin
        tima_nxt = tima + 8'd1;
      end
    end
  end
`endif

  // TIMA register.
  always_ff @(posedge clk) begin
    if (!rst_n) tima <= '0;
    else        tima <= tima_nxt;
  end

  // Interrupt request: one-clk pulse, one clk after the reload edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reload_p0 <= 1'b0;
      irq_timer <= 1'b0;
    end else begin
      reload_p0 <= reload_evt;
      irq_timer <= reload_p0;
    end
  end

endmodule

// File: tb/tb_sm83_timer.sv
// tb_sm83_timer: directed self-checking bench for sm83_timer.
// Expectations follow the SM83_TIMER_OVF_DELAY_EN setting of the build.
module tb_sm83_timer;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  w_data;
  logic        w_wen;
  logic [7:0]  r_data;
  logic        sel;
  logic        irq_timer;

  int checks;
  int failures;

  sm83_timer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .w_data    (w_data),
    .w_wen     (w_wen),
    .r_data    (r_data),
    .sel       (sel),
    .irq_timer (irq_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr   = a;
    w_data = d;
    w_wen  = 1'b1;
    @(posedge clk);
    #1;
    w_wen  = 1'b0;
    addr   = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = r_data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Leaves the bench just after edge D+1, where D is a DIV write; the first
  // TIMA tick edge (tap bit 3 falling) is then edge D+17.
  task automatic setup_run(input logic [7:0] tma_v, input logic [7:0] tima_v);
    wr(A_TAC, 8'h00);
    wr(A_TMA, tma_v);
    wr(A_TIMA, tima_v);
    wr(A_DIV, 8'h00);
    wr(A_TAC, 8'h05);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    checks++; if (irq_timer !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_timer); end
    rd(A_DIV, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_div got=%h exp=00", d); end
    rd(A_TIMA, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_tima got=%h exp=00", d); end
    rd(A_TMA, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_tma got=%h exp=00", d); end
    rd(A_TAC, d);
    checks++; if (d !== 8'hF8) begin failures++; $display("FAIL reset_tac got=%h exp=f8", d); end
    rd(16'hFF03, d);
    checks++; if (sel !== 1'b0 || d !== 8'h00) begin failures++; $display("FAIL unsel_ff03 got=%b/%h exp=0/00", sel, d); end
    rd(16'hFF08, d);
    checks++; if (sel !== 1'b0 || d !== 8'h00) begin failures++; $display("FAIL unsel_ff08 got=%b/%h exp=0/00", sel, d); end
    rd(A_TIMA, d);
    checks++; if (sel !== 1'b1) begin failures++; $display("FAIL sel_ff05 got=%b exp=1", sel); end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    wr(A_TMA, 8'h3C);
    rd(A_TMA, d);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL tma_rw got=%h exp=3c", d); end
    wr(A_TAC, 8'hFA);
    rd(A_TAC, d);
    checks++; if (d !== 8'hFA) begin failures++; $display("FAIL tac_rw_a got=%h exp=fa", d); end
    wr(A_TAC, 8'h01);
    rd(A_TAC, d);
    checks++; if (d !== 8'hF9) begin failures++; $display("FAIL tac_rw_b got=%h exp=f9", d); end
    wr(A_TAC, 8'h00);
  endtask

  task automatic test_div();
    logic [7:0] d;
    do_reset();
    cycles(256);
    rd(A_DIV, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL div_256 got=%h exp=01", d); end
    cycles(16'h12AB - 16'h0100);
    rd(A_DIV, d);
    checks++; if (d !== 8'h12) begin failures++; $display("FAIL div_12ab got=%h exp=12", d); end
    wr(A_DIV, 8'h5A);
    rd(A_DIV, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL div_clear got=%h exp=00", d); end
    cycles(256);
    rd(A_DIV, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL div_after_clear got=%h exp=01", d); end
  endtask

  task automatic test_timer();
    logic [7:0] d;
    setup_run(8'h00, 8'h00);
    cycles(15);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL tima_pre_tick got=%h exp=00", d); end
    cycles(1);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL tima_first_tick got=%h exp=01", d); end
    cycles(16);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL tima_second_tick got=%h exp=02", d); end
    cycles(239);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h10) begin failures++; $display("FAIL tima_256clk got=%h exp=10", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [7:0] exp_tima;
    logic       exp_irq;
    setup_run(8'hAB, 8'hFF);
    cycles(15);
    rd(A_TIMA, d);
    checks++; if (d !== 8'hFF || irq_timer !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%h/%b exp=ff/0", d, irq_timer); end
    for (int k = 0; k < 7; k++) begin
      cycles(1);
`ifdef SM83_TIMER_OVF_DELAY_EN
      exp_tima = (k < 4) ? 8'h00 : 8'hAB;
      exp_irq  = (k == 5);
`else
      exp_tima = 8'hAB;
      exp_irq  = (k == 1);
`endif
      checks++; if (irq_timer !== exp_irq) begin failures++; $display("FAIL ovf_irq_e%0d got=%b exp=%b", k, irq_timer, exp_irq); end
      rd(A_TIMA, d);
      checks++; if (d !== exp_tima) begin failures++; $display("FAIL ovf_tima_e%0d got=%h exp=%h", k, d, exp_tima); end
    end
  endtask

  task automatic test_tima_write_on_tick();
    logic [7:0] d;
    setup_run(8'hAB, 8'hFF);
    cycles(15);
    wr(A_TIMA, 8'h42);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h42) begin failures++; $display("FAIL wr_on_tick got=%h exp=42", d); end
    for (int k = 0; k < 6; k++) begin
      cycles(1);
      checks++; if (irq_timer !== 1'b0) begin failures++; $display("FAIL wr_on_tick_irq%0d got=%b exp=0", k, irq_timer); end
    end
    rd(A_TIMA, d);
    checks++; if (d !== 8'h42) begin failures++; $display("FAIL wr_on_tick_hold got=%h exp=42", d); end
  endtask

`ifdef SM83_TIMER_OVF_DELAY_EN
  task automatic test_ovf_write();
    logic [7:0] d;
    setup_run(8'hAB, 8'hFF);
    cycles(17);
    wr(A_TIMA, 8'h42);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h42) begin failures++; $display("FAIL ovf_wr got=%h exp=42", d); end
    for (int k = 0; k < 6; k++) begin
      cycles(1);
      checks++; if (irq_timer !== 1'b0) begin failures++; $display("FAIL ovf_wr_irq%0d got=%b exp=0", k, irq_timer); end
      rd(A_TIMA, d);
      checks++; if (d !== 8'h42) begin failures++; $display("FAIL ovf_wr_tima%0d got=%h exp=42", k, d); end
    end
  endtask

  task automatic test_reload_tma();
    logic [7:0] d;
    setup_run(8'hAB, 8'hFF);
    cycles(19);
    wr(A_TMA, 8'h5A);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL reload_tma got=%h exp=5a", d); end
    checks++; if (irq_timer !== 1'b0) begin failures++; $display("FAIL reload_tma_irq4 got=%b exp=0", irq_timer); end
    cycles(1);
    checks++; if (irq_timer !== 1'b1) begin failures++; $display("FAIL reload_tma_irq5 got=%b exp=1", irq_timer); end
  endtask
`endif

  task automatic test_glitch();
    logic [7:0] d;
    wr(A_TAC, 8'h00);
    wr(A_TIMA, 8'h10);
    wr(A_DIV, 8'h00);
    wr(A_TAC, 8'h04);
    cycles(599);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h10) begin failures++; $display("FAIL glitch_pre got=%h exp=10", d); end
    wr(A_DIV, 8'h00);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h10) begin failures++; $display("FAIL div_glitch_0 got=%h exp=10", d); end
    cycles(1);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL div_glitch_1 got=%h exp=11", d); end
    cycles(1);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL div_glitch_2 got=%h exp=11", d); end
    wr(A_DIV, 8'h00);
    cycles(600);
    wr(A_TAC, 8'h00);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL tac_glitch_0 got=%h exp=11", d); end
    cycles(1);
    rd(A_TIMA, d);
    checks++; if (d !== 8'h12) begin failures++; $display("FAIL tac_glitch_1 got=%h exp=12", d); end
  endtask

  task automatic test_reset_ovf();
    logic [7:0] d;
    setup_run(8'hAB, 8'hFF);
    cycles(16);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    checks++; if (irq_timer !== 1'b0) begin failures++; $display("FAIL rst_ovf_irq got=%b exp=0", irq_timer); end
    rd(A_TIMA, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_ovf_tima got=%h exp=00", d); end
    rd(A_TMA, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_ovf_tma got=%h exp=00", d); end
    rd(A_TAC, d);
    checks++; if (d !== 8'hF8) begin failures++; $display("FAIL rst_ovf_tac got=%h exp=f8", d); end
    rd(A_DIV, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_ovf_div got=%h exp=00", d); end
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      checks++; if (irq_timer !== 1'b0) begin failures++; $display("FAIL rst_ovf_irq%0d got=%b exp=0", k, irq_timer); end
    end
    rd(A_TIMA, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_ovf_tima_hold got=%h exp=00", d); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    addr     = 16'h0000;
    w_data   = 8'h00;
    w_wen    = 1'b0;
    test_reset();
    test_regs();
    test_div();
    test_timer();
    test_overflow();
    test_tima_write_on_tick();
`ifdef SM83_TIMER_OVF_DELAY_EN
    test_ovf_write();
    test_reload_tma();
`endif
    test_glitch();
    test_reset_ovf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
